// File: rtl/sort_checker_pkg.sv
// Shared types and constants for the sort_checker packet sink.
package sort_pkg;

  typedef enum logic [1:0] {IDLE_S, RX_S, REPORT_S} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Avalon-ST beat channel between the sorting block (master) and the checker (slave).
interface sort_checker_if #(
  parameter int DWIDTH = 8
) ();

  logic [DWIDTH-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic              valid;
  logic              ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);

endinterface

// File: rtl/sort_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random sink stalls.
module lfsr16
  import sort_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/sort_checker.sv
// Avalon-ST sink checking framing, non-decreasing data order and packet length.
// Optional random backpressure when SORT_CHECKER_BACKPRESSURE_EN is defined.
module sort_checker
  import sort_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_W       = 16
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  sort_checker_if.slave                       snk,
  output logic                                pkt_done_o,
  output logic [len_width(MAX_PKT_LEN)-1:0]   pkt_len_o,
  output logic                                pkt_order_err_o,
  output logic                                pkt_len_err_o,
  output logic                                framing_err_o,
  output logic [CNT_W-1:0]                    pkt_cnt_o,
  output logic [CNT_W-1:0]                    err_cnt_o
);

  localparam int            LW      = len_width(MAX_PKT_LEN);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LEN);

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d, rpt_len_q, rpt_len_d;
  logic [DWIDTH-1:0]   prev_q, prev_d;
  logic                ord_q, ord_d, lerr_q, lerr_d;
  logic                rpt_ord_q, rpt_ord_d, rpt_lerr_q, rpt_lerr_d;
  logic                ferr_q, ferr_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic                rdy_en_q;
  logic                stall, accept, pkt_inc, err_inc;

`ifdef SORT_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .en_i    (1'b1),
    .state_o (lfsr)
  );
  assign stall = lfsr[1] & lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // rdy_en_q keeps ready low until the first edge after reset release
  assign snk.ready = rdy_en_q & (state_q != REPORT_S) & ~stall;
  assign accept    = snk.valid & snk.ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    prev_d     = prev_q;
    ord_d      = ord_q;
    lerr_d     = lerr_q;
    rpt_len_d  = rpt_len_q;
    rpt_ord_d  = rpt_ord_q;
    rpt_lerr_d = rpt_lerr_q;
    ferr_d     = 1'b0;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      IDLE_S, RX_S: begin
        if (accept) begin
          if (snk.startofpacket) begin
            // nested SOP in RX_S drops the open packet and restarts
            if (state_q == RX_S) begin
              ferr_d  = 1'b1;
              err_inc = 1'b1;
            end
            len_d   = LW'(1);
            prev_d  = snk.data;
            ord_d   = 1'b0;
            lerr_d  = 1'b0;
            state_d = snk.endofpacket ? REPORT_S : RX_S;
          end else if (state_q == IDLE_S) begin
            ferr_d  = 1'b1;
            err_inc = 1'b1;
          end else begin
            if (snk.data < prev_q) ord_d = 1'b1;
            prev_d = snk.data;
            if (len_q == MAX_LEN) lerr_d = 1'b1;
            else                  len_d  = len_q + LW'(1);
            if (snk.endofpacket) state_d = REPORT_S;
          end
        end
      end
      REPORT_S: begin
        pkt_inc = 1'b1;
        err_inc = ord_q | lerr_q;
        state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase

    // Latch the report on entry so it is valid during the done cycle
    if (state_d == REPORT_S && state_q != REPORT_S) begin
      rpt_len_d  = len_d;
      rpt_ord_d  = ord_d;
      rpt_lerr_d = lerr_d;
    end

    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pkt_inc && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
    if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE_S;
      len_q      <= '0;
      prev_q     <= '0;
      ord_q      <= 1'b0;
      lerr_q     <= 1'b0;
      rpt_len_q  <= '0;
      rpt_ord_q  <= 1'b0;
      rpt_lerr_q <= 1'b0;
      ferr_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      prev_q     <= prev_d;
      ord_q      <= ord_d;
      lerr_q     <= lerr_d;
      rpt_len_q  <= rpt_len_d;
      rpt_ord_q  <= rpt_ord_d;
      rpt_lerr_q <= rpt_lerr_d;
      ferr_q     <= ferr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign pkt_done_o      = (state_q == REPORT_S);
  assign pkt_len_o       = rpt_len_q;
  assign pkt_order_err_o = rpt_ord_q;
  assign pkt_len_err_o   = rpt_lerr_q;
  assign framing_err_o   = ferr_q;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker: DUT a uses MAX_PKT_LEN=256, DUT b uses MAX_PKT_LEN=4.
module tb_sort_checker;

  logic clk = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk = ~clk;

  sort_checker_if #(.DWIDTH(8)) if_a ();
  sort_checker_if #(.DWIDTH(8)) if_b ();

  logic        done_a, ord_a, lerr_a, ferr_a;
  logic [8:0]  len_a;
  logic [15:0] pcnt_a, ecnt_a;
  logic        done_b, ord_b, lerr_b, ferr_b;
  logic [2:0]  len_b;
  logic [15:0] pcnt_b, ecnt_b;

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(256), .CNT_W(16)) dut_a (
    .clk_i(clk), .arst_i(arst_i), .snk(if_a),
    .pkt_done_o(done_a), .pkt_len_o(len_a), .pkt_order_err_o(ord_a),
    .pkt_len_err_o(lerr_a), .framing_err_o(ferr_a),
    .pkt_cnt_o(pcnt_a), .err_cnt_o(ecnt_a)
  );

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(4), .CNT_W(16)) dut_b (
    .clk_i(clk), .arst_i(arst_i), .snk(if_b),
    .pkt_done_o(done_b), .pkt_len_o(len_b), .pkt_order_err_o(ord_b),
    .pkt_len_err_o(lerr_b), .framing_err_o(ferr_b),
    .pkt_cnt_o(pcnt_b), .err_cnt_o(ecnt_b)
  );

  int n_chk = 0, n_err = 0;
  int n_done_a = 0, n_ferr_a = 0, n_done_b = 0;
  logic [8:0] last_len_a = '0;
  logic [2:0] last_len_b = '0;
  logic last_ord_a = 1'b0, last_lerr_a = 1'b0, last_ord_b = 1'b0, last_lerr_b = 1'b0;

  // Capture one-cycle result pulses away from the active edge
  always @(negedge clk) begin
    if (done_a) begin
      n_done_a    <= n_done_a + 1;
      last_len_a  <= len_a;
      last_ord_a  <= ord_a;
      last_lerr_a <= lerr_a;
    end
    if (ferr_a) n_ferr_a <= n_ferr_a + 1;
    if (done_b) begin
      n_done_b    <= n_done_b + 1;
      last_len_b  <= len_b;
      last_ord_b  <= ord_b;
      last_lerr_b <= lerr_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat to DUT sel (0=a, 1=b) and hold it until accepted
  task automatic send(input int sel, input logic [7:0] d, input logic s, input logic e);
    int n;
    logic rdy;
    if_a.data = d; if_a.startofpacket = s; if_a.endofpacket = e;
    if_b.data = d; if_b.startofpacket = s; if_b.endofpacket = e;
    if_a.valid = (sel == 0);
    if_b.valid = (sel == 1);
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (sel == 0) ? if_a.ready : if_b.ready;
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if_a.valid = 1'b0;
    if_b.valid = 1'b0;
  endtask

  int d0, f0;

  initial begin
    if_a.data = '0; if_a.startofpacket = 1'b0; if_a.endofpacket = 1'b0; if_a.valid = 1'b0;
    if_b.data = '0; if_b.startofpacket = 1'b0; if_b.endofpacket = 1'b0; if_b.valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", if_a.ready, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pkt_cnt", pcnt_a, 0);
    chk("rst_err_cnt", ecnt_a, 0);
    chk("rst_len", len_a, 0);
    arst_i = 1'b0;
    @(posedge clk);
    #1;
`ifndef SORT_CHECKER_BACKPRESSURE_EN
    chk("ready_after_rst", if_a.ready, 1);
`endif

    // sorted packet 1,2,2,7,9
    d0 = n_done_a;
    send(0, 8'd1, 1, 0); send(0, 8'd2, 0, 0); send(0, 8'd2, 0, 0);
    send(0, 8'd7, 0, 0); send(0, 8'd9, 0, 1);
    idle(3);
    chk("sorted_done", n_done_a - d0, 1);
    chk("sorted_len", last_len_a, 5);
    chk("sorted_ord", last_ord_a, 0);
    chk("sorted_lerr", last_lerr_a, 0);
    chk("sorted_pkt_cnt", pcnt_a, 1);
    chk("sorted_err_cnt", ecnt_a, 0);

    // descending pair 3,5,4
    send(0, 8'd3, 1, 0); send(0, 8'd5, 0, 0); send(0, 8'd4, 0, 1);
    idle(3);
    chk("desc_ord", last_ord_a, 1);
    chk("desc_len", last_len_a, 3);
    chk("desc_pkt_cnt", pcnt_a, 2);
    chk("desc_err_cnt", ecnt_a, 1);

    // single beat: report exactly one cycle after acceptance
    send(0, 8'h55, 1, 1);
    @(negedge clk);
    chk("single_latency", done_a, 1);
    chk("single_len", len_a, 1);
    chk("single_ord", ord_a, 0);
    chk("single_lerr", lerr_a, 0);
    idle(3);
    chk("single_pkt_cnt", pcnt_a, 3);
    chk("single_err_cnt", ecnt_a, 1);

    // orphan beat, then SOP 1, nested SOP 0, EOP 2
    d0 = n_done_a; f0 = n_ferr_a;
    send(0, 8'd9, 0, 0);
    send(0, 8'd1, 1, 0); send(0, 8'd0, 1, 0); send(0, 8'd2, 0, 1);
    idle(3);
    chk("frame_pulses", n_ferr_a - f0, 2);
    chk("frame_done", n_done_a - d0, 1);
    chk("frame_len", last_len_a, 2);
    chk("frame_ord", last_ord_a, 0);
    chk("frame_err_cnt", ecnt_a, 3);

    // MAX_PKT_LEN=4 instance: 6-beat packet saturates at 4
    for (int i = 1; i <= 6; i++) send(1, 8'(i), i == 1, i == 6);
    idle(3);
    chk("long_done", n_done_b, 1);
    chk("long_len", last_len_b, 4);
    chk("long_lerr", last_lerr_b, 1);
    chk("long_ord", last_ord_b, 0);
    chk("long_err_cnt", ecnt_b, 1);

    // reset mid-packet, then a fresh packet with random gaps
    d0 = n_done_a;
    send(0, 8'd1, 1, 0); send(0, 8'd2, 0, 0);
    arst_i = 1'b1;
    #2;
    chk("midrst_pkt_cnt", pcnt_a, 0);
    chk("midrst_err_cnt", ecnt_a, 0);
    chk("midrst_ready", if_a.ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_no_report", n_done_a - d0, 0);
    idle($urandom_range(0, 3));
    send(0, 8'd4, 1, 0);
    idle($urandom_range(0, 3));
    send(0, 8'd6, 0, 0);
    idle($urandom_range(0, 3));
    send(0, 8'd6, 0, 1);
    idle(3);
    chk("post_rst_done", n_done_a - d0, 1);
    chk("post_rst_len", last_len_a, 3);
    chk("post_rst_pkt_cnt", pcnt_a, 1);
    chk("post_rst_err_cnt", ecnt_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
